// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: debounce state encoding,
// frame classification and the key-code width helper.
package keypad_pkg;

  // Debounce FSM states
  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Summary of one complete scan frame
  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_class_t;

  // Width of a raw key code, code = col*rows + row
  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small synchronous key FIFO. Pointers wrap naturally (DEPTH is a power
// of two); a separate occupancy count tells full from empty. A push into a
// full FIFO that is not popping in the same cycle is dropped and flagged.
module keypad_key_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array, no reset needed: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling,
// whole-frame debounce with ghosting rejection, and a key-code FIFO.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat of the held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int FREQ_HZ         = 50000000,
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 2500,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY_FRAMES = 100,
  parameter int REPEAT_RATE_FRAMES  = 20,
`endif
  localparam int KW = code_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] filas,
  output logic [COLS-1:0] columnas,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow,
  input  logic            ovf_clr
);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int NW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [ROWS-1:0] filas_m, filas_s;
  logic [CW-1:0]   c;
  logic [DW-1:0]   d;
  logic            sample, frame_end;
  logic [1:0]      acc_cnt, sum_cnt;
  logic [KW-1:0]   acc_code, sum_code;
  frame_class_t    fclass;
  logic            single_held;
  logic [1:0]      st;
  logic [NW-1:0]   n;
  logic [KW-1:0]   cand;
  logic            push_q;
  logic            fifo_full, fifo_empty, fifo_drop;
  logic            unused_full;
  logic [31:0]     unused_freq;

  // FREQ_HZ is informational; full is implied by the drop pulse here
  assign unused_full = fifo_full;
  assign unused_freq = 32'(FREQ_HZ);

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (rst) begin
      filas_m <= '0;
      filas_s <= '0;
    end else begin
      filas_m <= filas;
      filas_s <= filas_m;
    end
  end

  assign sample    = (d == DW'(SCAN_CYCLES - 1));
  assign frame_end = sample && (c == CW'(COLS - 1));
  assign columnas  = {{(COLS-1){1'b0}}, 1'b1} << c;

  // Column index and dwell counter
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      d <= '0;
    end else if (sample) begin
      d <= '0;
      c <= frame_end ? '0 : c + CW'(1);
    end else begin
      d <= d + DW'(1);
    end
  end

  // Fold the current column's rows into the running frame summary
  always_comb begin
    sum_cnt  = acc_cnt;
    sum_code = acc_code;
    for (int r = 0; r < ROWS; r++) begin
      if (filas_s[r]) begin
        sum_cnt  = (sum_cnt == 2'd2) ? 2'd2 : sum_cnt + 2'd1;
        sum_code = KW'(int'(c) * ROWS + r);
      end
    end
  end

  // Frame accumulator, cleared after each frame is classified
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      acc_cnt  <= frame_end ? 2'd0 : sum_cnt;
      acc_code <= frame_end ? '0 : sum_code;
    end
  end

  assign fclass      = (sum_cnt == 2'd0) ? FR_NONE :
                       (sum_cnt == 2'd1) ? FR_SINGLE : FR_MULTI;
  assign single_held = (fclass == FR_SINGLE) && (sum_code == cand);

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                        REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_rate;
  int            rep_thr;
  logic          rep_due;

  assign rep_thr = rep_rate ? REPEAT_RATE_FRAMES : REPEAT_DELAY_FRAMES;
  assign rep_due = (int'(rep_cnt) + 1) >= rep_thr;
`endif

  // Debounce FSM, advanced once per frame; push is registered so key_held
  // leads key_valid by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_RELEASED;
      n      <= '0;
      cand   <= '0;
      push_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= '0;
      rep_rate <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (frame_end) begin
        case (st)
          ST_RELEASED: begin
            if (fclass == FR_SINGLE) begin
              cand <= sum_code;
              n    <= NW'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                st     <= ST_PRESSED;
                push_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt  <= '0;
                rep_rate <= 1'b0;
`endif
              end else begin
                st <= ST_PRESS_WAIT;
              end
            end
          end
          ST_PRESS_WAIT: begin
            if (single_held) begin
              if (n + NW'(1) == NW'(DEBOUNCE_FRAMES)) begin
                st     <= ST_PRESSED;
                push_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt  <= '0;
                rep_rate <= 1'b0;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              st <= ST_RELEASED;
            end
          end
          ST_PRESSED: begin
            if (fclass == FR_NONE) begin
              n  <= NW'(1);
              st <= (DEBOUNCE_FRAMES == 1) ? ST_RELEASED : ST_RELEASE_WAIT;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (single_held) begin
              if (rep_due) begin
                push_q   <= 1'b1;
                rep_cnt  <= '0;
                rep_rate <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
            end
`endif
          end
          default: begin
            if (fclass != FR_NONE) begin
              st <= ST_PRESSED;
            end else if (n + NW'(1) == NW'(DEBOUNCE_FRAMES)) begin
              st <= ST_RELEASED;
            end else begin
              n <= n + NW'(1);
            end
          end
        endcase
      end
    end
  end

  assign key_held  = (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
  assign key_valid = !fifo_empty;

  keypad_key_fifo #(
    .W     (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (cand),
    .pop   (key_valid && key_ready),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Sticky overflow; a drop in the same cycle beats the clear
  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clr)   overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A keypad matrix model closes
// row lines from a key bitmask; a frame-level reference (popcount rules,
// press/release streaks and a queue) predicts the DUT outputs.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SC = 8, DF = 3, DEPTH = 4, KW = 4;
  localparam int FRAME = COLS * SC;
`ifdef KEYPAD_REPEAT_EN
  localparam int RD = 4, RR = 2;
`endif

  logic clk = 1'b0, rst = 1'b1, key_ready = 1'b0, ovf_clr = 1'b0;
  logic [ROWS-1:0] filas;
  logic [COLS-1:0] columnas;
  logic key_valid, key_held, overflow;
  logic [KW-1:0] key_code;
  logic [ROWS*COLS-1:0] keys = '0;

  int n_checks = 0, n_fail = 0;
  int q[$];
  bit m_held, m_ovf, m_rate, pop_now;
  int m_cnt, m_code, m_rep;

  always #5 clk = ~clk;

  // Keypad matrix: a closed key connects its driven column to its row
  always_comb begin
    filas = '0;
    for (int cc = 0; cc < COLS; cc++)
      for (int rr = 0; rr < ROWS; rr++)
        if (columnas[cc] && keys[cc*ROWS+rr]) filas[rr] = 1'b1;
  end

  keypad_scanner #(
    .FREQ_HZ(50000000), .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SC),
`ifdef KEYPAD_REPEAT_EN
    .REPEAT_DELAY_FRAMES(RD), .REPEAT_RATE_FRAMES(RR),
`endif
    .DEBOUNCE_FRAMES(DF), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .filas(filas), .columnas(columnas),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int top_key(input logic [15:0] m);
    int k = -1;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    return k;
  endfunction

  task automatic model_push(input int k);
    if (q.size() < DEPTH) q.push_back(k);
    else m_ovf = 1'b1;
  endtask

  // Reference: a press needs DF consecutive frames of the same lone key
  // starting from idle; a release needs DF consecutive empty frames
  task automatic model_frame(input logic [15:0] m);
    int pc, k;
    pc = $countones(m);
    k  = top_key(m);
    if (!m_held) begin
      if (m_cnt > 0 && pc == 1 && k == m_code) m_cnt++;
      else if (m_cnt == 0 && pc == 1) begin m_code = k; m_cnt = 1; end
      else m_cnt = 0;
      if (m_cnt >= DF) begin
        model_push(m_code); m_held = 1'b1; m_cnt = 0; m_rep = 0; m_rate = 1'b0;
      end
    end else if (pc == 0) begin
      m_cnt++;
      if (m_cnt >= DF) begin m_held = 1'b0; m_cnt = 0; end
    end else begin
`ifdef KEYPAD_REPEAT_EN
      if (m_cnt == 0 && pc == 1 && k == m_code) begin
        m_rep++;
        if (m_rep >= (m_rate ? RR : RD)) begin model_push(m_code); m_rep = 0; m_rate = 1'b1; end
      end
`endif
      m_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; key_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    check("rst_col", columnas, 1);
    rst = 1'b0;
    q.delete(); m_held = 0; m_ovf = 0; m_cnt = 0; m_rep = 0; m_rate = 0; pop_now = 0;
  endtask

  // One scan frame with a fixed key mask, entered in the frame's first cycle.
  // npop: pops early in the frame; clr: pulse ovf_clr after them;
  // pop_end: pop in the same cycle as any push produced by this frame.
  task automatic run_frame(input logic [15:0] m, input int npop, input bit clr, input bit pop_end);
    keys = m;
    for (int e = 0; e < FRAME; e++) begin
      if (e >= 1) key_ready = 1'b0;
      if (e >= 1 && e <= npop && q.size() > 0) begin
        check("pop_code", key_code, q[0]);
        key_ready = 1'b1;
      end
      ovf_clr = clr && (e == npop + 1);
      @(posedge clk); #1;
      if (e >= 1 && key_ready) q.delete(0);
      if (ovf_clr) m_ovf = 1'b0;
      if (e == 0) begin
        key_ready = 1'b0;
        check("valid", key_valid, q.size() != 0);
        if (q.size() != 0) check("head", key_code, q[0]);
        check("ovf", overflow, m_ovf);
      end
      if (e >= 1 && e <= npop) check("valid_pop", key_valid, q.size() != 0);
      if (e == 19) check("columnas", columnas, 1 << (20 / SC));
      if (e == FRAME - 1) begin
        check("valid_lag", key_valid, q.size() != 0);
        if (pop_end && q.size() > 0) begin
          check("pop_code_end", key_code, q[0]);
          q.delete(0);
          key_ready = 1'b1;
        end
        model_frame(m);
        check("held", key_held, m_held);
      end
    end
  endtask

  task automatic press(input int k, input bit pop_end);
    run_frame(16'(1) << k, 0, 0, 0);
    run_frame(16'(1) << k, 0, 0, 0);
    run_frame(16'(1) << k, 0, 0, pop_end);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] rm;
    int kind, len;
    do_reset();

    // single press of code 6 (column 1, row 2)
    for (int i = 0; i < 5; i++) run_frame(16'(1) << 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    check("single_valid", key_valid, 1);
    check("single_code", key_code, 6);
    run_frame('0, 1, 0, 0);
    check("single_empty", key_valid, 0);

    // bounce on code 12 (column 3, row 0)
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 16'(1) << 12 : 16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    check("bounce_valid", key_valid, 0);
    check("bounce_held", key_held, 0);

    // ghosting: 6 held, then 9 added
    for (int i = 0; i < 4; i++) run_frame(16'(1) << 6, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_frame(16'h0240, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    check("ghost_code", key_code, 6);
    check("ghost_held", key_held, 0);
    run_frame('0, 1, 0, 0);
    check("ghost_one", key_valid, 0);

    // overflow: five presses into a four-entry FIFO
    for (int k = 1; k <= 5; k++) press(k, 0);
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 1);
    run_frame('0, 4, 1, 0);
    check("ovf_drained", key_valid, 0);
    check("ovf_clr", overflow, 0);

    // push and pop in the same cycle while full: no drop
    for (int k = 10; k <= 13; k++) press(k, 0);
    press(14, 1);
    check("full_pp_ovf", overflow, 0);
    check("full_pp_head", key_code, 11);
    run_frame('0, 4, 0, 0);

    // reset mid-frame during PRESS_WAIT with two codes queued
    press(1, 0);
    press(2, 0);
    run_frame(16'(1) << 3, 0, 0, 0);
    keys = 16'(1) << 3;
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) run_frame(16'(1) << 3, 0, 0, 0);
    check("post_rst_code", key_code, 3);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    run_frame('0, 1, 0, 0);

`ifdef KEYPAD_REPEAT_EN
    // auto-repeat: pushes at frames 3, 7, 9 and 11
    for (int i = 1; i <= 12; i++) begin
      run_frame(16'(1) << 5, 0, 0, 0);
      if (i == 6) check("rep_one", q.size() == 1 && key_code == 5, 1);
    end
    check("rep_head", key_code, 5);
    check("rep_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    run_frame('0, 4, 0, 0);
    check("rep_drained", key_valid, 0);
`endif

    // randomized key activity against the reference model
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (kind < 5) rm = 16'(1) << $urandom_range(0, 15);
      else if (kind < 7) rm = '0;
      else rm = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      for (int j = 0; j < len; j++)
        run_frame(rm, (q.size() > 2) ? int'($urandom_range(0, 2)) : 0, 0,
                  $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 3; i++) run_frame('0, 0, 0, 0);
    run_frame('0, 4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
